obs_ctrl: RTL and testbench

Obstacle position controller for the Dino game. It produces the obstacle x-coordinate that the obstacle renderer consumes on its `i_xpos` input. Once per frame it waits a pseudo-random number of frames, spawns the obstacle just off the right screen edge, and scrolls it left at the game speed. It signals when the obstacle leaves the screen (for scoring) and freezes the obstacle on collision.

---
 rtl/obs_ctrl.sv | 120 ++++++++++++
 tb/tb_obs_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/obs_ctrl.sv
// Obstacle position controller for the Dino game: waits a pseudo-random number
// of frames, spawns the obstacle off the right edge and scrolls it left each frame.
module obs_ctrl #(
  parameter int CONV     = 0,
  parameter int SCREEN_W = 640,
  parameter int SPRITE_W = 16,
  parameter int MIN_GAP  = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_frame_tick,
  input  logic          i_start,
  input  logic          i_collision,
  input  logic [3:0]    i_speed,
  output logic [9:CONV] o_xpos,
  output logic          o_active,
  output logic          o_passed
);

  localparam int W = 10 - CONV;
  localparam logic [9:CONV] SPAWN_X = W'(SCREEN_W + SPRITE_W);
  localparam logic [15:0]   LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_MOVE = 2'd2,
    S_HALT = 2'd3
  } state_t;

  function automatic logic lfsr_fb(input logic [15:0] v);
    return v[15] ^ v[13] ^ v[12] ^ v[10];
  endfunction

  state_t        r_state, w_state_n;
  logic [9:CONV] r_xpos, w_xpos_n;
  logic [6:0]    r_cnt, w_cnt_n;
  logic [15:0]   r_lfsr, w_lfsr_n;
  logic          r_active, w_active_n;
  logic          r_passed, w_passed_n;
  logic [9:CONV] w_step;
  logic [6:0]    w_delay;

  assign w_step  = (i_speed == 4'd0) ? W'(1) : W'(i_speed);
  // Delay uses the LFSR value before this cycle's advance.
  assign w_delay = 7'(MIN_GAP) + {1'b0, r_lfsr[5:0]};

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_xpos   <= {W{1'b0}};
      r_cnt    <= 7'd0;
      r_lfsr   <= LFSR_SEED;
      r_active <= 1'b0;
      r_passed <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_xpos   <= w_xpos_n;
      r_cnt    <= w_cnt_n;
      r_lfsr   <= w_lfsr_n;
      r_active <= w_active_n;
      r_passed <= w_passed_n;
    end
  end

  // Next-state, position, wait counter and LFSR.
  always_comb begin
    w_state_n  = r_state;
    w_xpos_n   = r_xpos;
    w_cnt_n    = r_cnt;
    w_passed_n = 1'b0;
    if (i_frame_tick) begin
      w_lfsr_n = {r_lfsr[14:0], lfsr_fb(r_lfsr)};
    end else begin
      w_lfsr_n = r_lfsr;
    end

    if (i_start) begin
      w_state_n = S_WAIT;
      w_xpos_n  = {W{1'b0}};
      w_cnt_n   = w_delay;
    end else if (i_frame_tick) begin
      case (r_state)
        S_WAIT: begin
          if (r_cnt == 7'd0) begin
            w_state_n = S_MOVE;
            w_xpos_n  = SPAWN_X;
          end else begin
            w_cnt_n = r_cnt - 7'd1;
          end
        end
        S_MOVE: begin
          if (i_collision) begin
            w_state_n = S_HALT;
          end else if (r_xpos <= w_step) begin
            w_state_n  = S_WAIT;
            w_xpos_n   = {W{1'b0}};
            w_passed_n = 1'b1;
            w_cnt_n    = w_delay;
          end else begin
            w_xpos_n = r_xpos - w_step;
          end
        end
        S_IDLE:  w_state_n = S_IDLE;
        S_HALT:  w_state_n = S_HALT;
        default: w_state_n = S_IDLE;
      endcase
    end else begin
      w_state_n = r_state;
    end

    w_active_n = (w_state_n == S_MOVE) || (w_state_n == S_HALT);
  end

  assign o_xpos   = r_xpos;
  assign o_active = r_active;
  assign o_passed = r_passed;

endmodule

// File: tb/tb_obs_ctrl.sv
// Self-checking bench for obs_ctrl: a behavioural model pushes expected outputs
// per driven cycle; the DUT outputs are popped and compared after each edge.
module tb_obs_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_frame_tick = 1'b0;
  logic       i_start = 1'b0;
  logic       i_collision = 1'b0;
  logic [3:0] i_speed = 4'd4;
  logic [9:0] o_xpos;
  logic       o_active;
  logic       o_passed;

  int n_err = 0;
  int n_chk = 0;

  obs_ctrl dut (
    .clk(clk), .rst(rst), .i_frame_tick(i_frame_tick), .i_start(i_start),
    .i_collision(i_collision), .i_speed(i_speed),
    .o_xpos(o_xpos), .o_active(o_active), .o_passed(o_passed)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int act; int pas; } exp_t;
  exp_t sb_q[$];

  // Model state: 0 idle, 1 wait, 2 move, 3 halt
  logic [15:0] m_lfsr = 16'hACE1;
  int m_st = 0, m_x = 0, m_cnt = 0, m_d = 0, m_pas = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model(input bit r, input bit t, input bit s, input bit c, input logic [3:0] sp);
    logic [15:0] nl;
    int step;
    m_pas = 0;
    if (r) begin
      m_lfsr = 16'hACE1; m_st = 0; m_x = 0; m_cnt = 0;
    end else begin
      nl = t ? {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]} : m_lfsr;
      step = (sp == 4'd0) ? 1 : int'(sp);
      if (s) begin
        m_st = 1; m_x = 0; m_cnt = 20 + int'(m_lfsr[5:0]); m_d = m_cnt;
      end else if (t) begin
        if (m_st == 1) begin
          if (m_cnt == 0) begin m_st = 2; m_x = 656; end
          else m_cnt--;
        end else if (m_st == 2) begin
          if (c) m_st = 3;
          else if (m_x <= step) begin
            m_x = 0; m_pas = 1; m_st = 1; m_cnt = 20 + int'(m_lfsr[5:0]); m_d = m_cnt;
          end else m_x -= step;
        end
      end
      m_lfsr = nl;
    end
  endtask

  // Drive one cycle, predict, then compare after the edge.
  task automatic cyc(input string tag, input bit r, input bit t, input bit s,
                     input bit c, input logic [3:0] sp);
    exp_t e;
    rst = r; i_frame_tick = t; i_start = s; i_collision = c; i_speed = sp;
    model(r, t, s, c, sp);
    e.x = m_x; e.act = (m_st >= 2) ? 1 : 0; e.pas = m_pas;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk({tag, ".x"}, int'(o_xpos), e.x);
    chk({tag, ".act"}, int'(o_active), e.act);
    chk({tag, ".pas"}, int'(o_passed), e.pas);
    rst = 1'b0; i_frame_tick = 1'b0; i_start = 1'b0;
  endtask

  // Tick until the obstacle appears; bounded.
  task automatic wait_spawn(input string tag, output int n);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      cyc(tag, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4);
      n++;
      if (o_xpos != 10'd0) break;
    end
  endtask

  int n;

  initial begin
    // Reset, then ten idle ticks
    cyc("rst", 1'b1, 1'b0, 1'b0, 1'b0, 4'd4);
    cyc("rst", 1'b1, 1'b0, 1'b0, 1'b0, 4'd4);
    for (int k = 0; k < 10; k++) cyc("idle", 1'b0, 1'b1, 1'b0, 1'b0, 4'd4);
    chk("lfsr10", int'(dut.r_lfsr), int'(m_lfsr));

    // Plain start from seed: D=53, spawn on tick 54
    cyc("rst2", 1'b1, 1'b0, 1'b0, 1'b0, 4'd4);
    cyc("start", 1'b0, 1'b0, 1'b1, 1'b0, 4'd4);
    wait_spawn("wait53", n);
    chk("spawn_ticks", n, 54);
    chk("spawn_x", int'(o_xpos), 656);
    chk("spawn_act", int'(o_active), 1);

    // Scroll by 4 to the left edge
    for (int k = 0; k < 163; k++) cyc("mv4", 1'b0, 1'b1, 1'b0, 1'b0, 4'd4);
    chk("x_at_4", int'(o_xpos), 4);
    cyc("leave", 1'b0, 1'b1, 1'b0, 1'b0, 4'd4);
    chk("leave_pas", int'(o_passed), 1);
    chk("leave_act", int'(o_active), 0);
    cyc("after", 1'b0, 1'b0, 1'b0, 1'b0, 4'd4);
    chk("pas_1cyc", int'(o_passed), 0);

    // Next spawn from a reloaded delay, then drive to 600 and collide
    wait_spawn("wait2", n);
    chk("spawn2_ticks", n, m_d + 1);
    for (int k = 0; k < 14; k++) cyc("mv600", 1'b0, 1'b1, 1'b0, 1'b0, 4'd4);
    chk("x_600", int'(o_xpos), 600);
    for (int k = 0; k < 21; k++) cyc("halt", 1'b0, 1'b1, 1'b0, 1'b1, 4'd15);
    chk("halt_x", int'(o_xpos), 600);
    chk("halt_act", int'(o_active), 1);
    cyc("restart", 1'b0, 1'b0, 1'b1, 1'b0, 4'd4);
    chk("restart_x", int'(o_xpos), 0);
    chk("restart_pas", int'(o_passed), 0);
    wait_spawn("wait3", n);
    chk("spawn3_ticks", n, m_d + 1);

    // Speed 0 behaves as step 1
    cyc("sp0", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("sp0_x", int'(o_xpos), 655);

    // Start mid-MOVE: vanishes, no pass pulse; then speed 15 run
    cyc("mid_start", 1'b0, 1'b0, 1'b1, 1'b0, 4'd15);
    chk("mid_start_x", int'(o_xpos), 0);
    chk("mid_start_pas", int'(o_passed), 0);
    wait_spawn("wait4", n);
    chk("spawn4_ticks", n, m_d + 1);
    for (int k = 0; k < 43; k++) cyc("mv15", 1'b0, 1'b1, 1'b0, 1'b0, 4'd15);
    chk("x_11", int'(o_xpos), 11);
    cyc("leave15", 1'b0, 1'b1, 1'b0, 1'b0, 4'd15);
    chk("leave15_x", int'(o_xpos), 0);
    chk("leave15_pas", int'(o_passed), 1);

    // Reset during MOVE, then start coincident with a tick: D is 53 again
    wait_spawn("wait5", n);
    cyc("mv", 1'b0, 1'b1, 1'b0, 1'b0, 4'd4);
    cyc("rst_mv", 1'b1, 1'b0, 1'b0, 1'b0, 4'd4);
    chk("rst_mv_x", int'(o_xpos), 0);
    chk("rst_mv_act", int'(o_active), 0);
    cyc("start_tick", 1'b0, 1'b1, 1'b1, 1'b0, 4'd4);
    chk("lfsr_adv", int'(dut.r_lfsr), int'(m_lfsr));
    wait_spawn("wait53b", n);
    chk("spawn_ticks_b", n, 54);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
